// File: rtl/axis_pkg.sv
// Shared defaults and state encoding for the sorted-packet stream receiver.
package axis_pkg;

  localparam int AXIS_WIDTH   = 16;
  localparam int AXIS_ADDRESS = 4;

  // RECV accepts beats; HOLD parks the captured packet until the host acks.
  typedef enum logic {
    RECV = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/sort_rx_mem.sv
// Packet buffer: DEPTH x WIDTH, one write port, one registered read port.
// A read and a write to the same address in one cycle returns the old word.
module sort_rx_mem
  import axis_pkg::*;
#(
  parameter int WIDTH   = AXIS_WIDTH,
  parameter int ADDRESS = AXIS_ADDRESS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDRESS-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [ADDRESS-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  localparam int DEPTH = 2 ** ADDRESS;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Storage array is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Array lookup feeding the read register.
  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  // Registered read port; clears on reset so rd_data is defined afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_sort_rx.sv
// Stream packet receiver: stores up to DEPTH beats, flags whether the packet
// was non-decreasing and whether it overran the buffer, then holds the result
// until the host acknowledges.
module axis_sort_rx
  import axis_pkg::*;
#(
  parameter int WIDTH   = AXIS_WIDTH,
  parameter int ADDRESS = AXIS_ADDRESS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ovalid,
  output logic               oready,
  input  logic               olast,
  input  logic [WIDTH-1:0]   odata,
  input  logic [ADDRESS-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  output logic               pkt_done,
  output logic [ADDRESS:0]   pkt_len,
  output logic               sorted,
  output logic               overflow,
  input  logic               ack
);

  localparam int DEPTH = 2 ** ADDRESS;
  localparam logic [ADDRESS:0] LEN_FULL = (ADDRESS + 1)'(DEPTH);

  state_t             state_q, state_d;
  logic [ADDRESS:0]   pkt_len_q, pkt_len_d;
  logic               sorted_q, sorted_d;
  logic               overflow_q, overflow_d;
  logic               pkt_done_q, pkt_done_d;
  logic               have_prev_q, have_prev_d;
  logic [WIDTH-1:0]   prev_q, prev_d;

  logic               beat;
  logic               wr_en;
  logic [ADDRESS-1:0] wr_addr;

  // Ready is a pure decode of the state register.
  assign oready  = (state_q == RECV);
  assign beat    = ovalid && oready;
  // Beats past the buffer end are still accepted but not stored.
  assign wr_en   = beat && (pkt_len_q != LEN_FULL);
  assign wr_addr = pkt_len_q[ADDRESS-1:0];

  // Next-state, counter and ordering logic.
  always_comb begin
    state_d     = state_q;
    pkt_len_d   = pkt_len_q;
    sorted_d    = sorted_q;
    overflow_d  = overflow_q;
    pkt_done_d  = 1'b0;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    case (state_q)
      RECV: begin
        if (beat) begin
          have_prev_d = 1'b1;
          prev_d      = odata;
          // Discarded overflow beats still take part in the ordering check.
          if (have_prev_q && (odata < prev_q)) begin
            sorted_d = 1'b0;
          end
          if (pkt_len_q == LEN_FULL) begin
            overflow_d = 1'b1;
          end else begin
            pkt_len_d = pkt_len_q + 1'b1;
          end
          if (olast) begin
            state_d    = HOLD;
            pkt_done_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (ack) begin
          state_d     = RECV;
          pkt_len_d   = '0;
          sorted_d    = 1'b1;
          overflow_d  = 1'b0;
          have_prev_d = 1'b0;
        end
      end
      default: begin
        state_d = RECV;
      end
    endcase
  end

  // State and status registers; reset wins over ack and beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RECV;
      pkt_len_q   <= '0;
      sorted_q    <= 1'b1;
      overflow_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      have_prev_q <= 1'b0;
      prev_q      <= '0;
    end else begin
      state_q     <= state_d;
      pkt_len_q   <= pkt_len_d;
      sorted_q    <= sorted_d;
      overflow_q  <= overflow_d;
      pkt_done_q  <= pkt_done_d;
      have_prev_q <= have_prev_d;
      prev_q      <= prev_d;
    end
  end

  assign pkt_len  = pkt_len_q;
  assign sorted   = sorted_q;
  assign overflow = overflow_q;
  assign pkt_done = pkt_done_q;

  sort_rx_mem #(
    .WIDTH  (WIDTH),
    .ADDRESS(ADDRESS)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(odata),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: doc/axis_sort_rx.md
AXIS_SORT_RX -- requirements
Module: axis_sort_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 16, stream data width in bits.
REQ-002 SHALL have parameter ADDRESS, default 4, buffer address width; depth DEPTH = 2**ADDRESS (16 words).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ovalid  input  1  upstream master beat valid.
REQ-006 SHALL have port oready  output  1  block ready to accept a beat.
REQ-007 SHALL have port olast  input  1  final beat of packet.
REQ-008 SHALL have port odata  input  WIDTH  beat payload.
REQ-009 SHALL have port rd_addr  input  ADDRESS  buffer read address.
REQ-010 SHALL have port rd_data  output  WIDTH  buffer read data.
REQ-011 SHALL have port pkt_done  output  1  one-cycle pulse: packet captured.
REQ-012 SHALL have port pkt_len  output  ADDRESS+1  stored word count (0..DEPTH).
REQ-013 SHALL have port sorted  output  1  packet non-decreasing (unsigned).
REQ-014 SHALL have port overflow  output  1  packet exceeded DEPTH words.
REQ-015 SHALL have port ack  input  1  host releases buffer, re-arms receiver.

Function
REQ-016 SHALL implement FSM states RECV and HOLD; reset state RECV.
REQ-017 SHALL drive oready = 1 in RECV, 0 in HOLD (registered state decode, no combinational path from ovalid).
REQ-018 SHALL count a beat only when ovalid && oready on a rising clk edge.
REQ-019 SHALL write beat n (n < DEPTH) to buffer address n; pkt_len increments per stored beat.
REQ-020 SHALL, for beats with index >= DEPTH, keep accepting (oready stays 1), discard data, hold pkt_len at DEPTH, set overflow.
REQ-021 SHALL compare each accepted beat after the first to the previous accepted beat (including discarded ones); odata < previous clears sorted; sorted never re-sets within a packet.
REQ-022 SHALL treat a first beat as sorted; single-beat packet yields sorted=1, pkt_len=1.
REQ-023 SHALL on an accepted beat with olast=1 move to HOLD next cycle and assert pkt_done for exactly that one cycle.
REQ-024 SHALL hold pkt_len, sorted, overflow stable throughout HOLD.
REQ-025 SHALL on ack=1 in HOLD return to RECV next cycle with pkt_len=0, sorted=1, overflow=0.
REQ-026 SHALL ignore ack in RECV.
REQ-027 SHALL provide rd_data one cycle after rd_addr (registered read), available in any state; addresses >= pkt_len return unspecified stale data.
REQ-028 SHALL give read-during-write on the same address old data.
REQ-029 SHALL ignore olast when ovalid=0; ovalid without olast never ends a packet.

Reset
REQ-030 SHALL on reset=1 set state RECV, oready=1 from the cycle after reset, pkt_len=0, sorted=1, overflow=0, pkt_done=0, rd_data=0.
REQ-031 SHALL abandon a partial packet on reset mid-packet; buffer contents need not be cleared.
REQ-032 SHALL give reset priority over ack and stream beats in the same cycle.

Structure
REQ-033 SHALL take WIDTH/ADDRESS defaults and the state enum (RECV, HOLD) from shared package axis_pkg.
REQ-034 SHALL instantiate one sub-module sort_rx_mem: DEPTH x WIDTH, one write port, one registered read port.
REQ-035 SHALL keep FSM, counter, compare logic in axis_sort_rx.

Verification
REQ-036 SHALL cover: packet 3,5,5,9 (olast on 9) -> pkt_done 1 cycle, pkt_len=4, sorted=1, overflow=0, rd_addr 0..3 read 3,5,5,9.
REQ-037 SHALL cover: packet 7,2,8 -> sorted=0, pkt_len=3; ack -> oready=1 next cycle, pkt_len=0, sorted=1.
REQ-038 SHALL cover: 20-beat ascending packet 0..19 -> pkt_len=16, overflow=1, sorted=1, addresses 0..15 read 0..15.
REQ-039 SHALL cover: random ovalid gaps and olast asserted with ovalid=0 -> no spurious beats, packet ends only on valid olast.
REQ-040 SHALL cover: beats arriving in HOLD -> oready=0, none stored; ack in RECV -> no effect.
REQ-041 SHALL cover: reset after 5 beats, then packet 1,2 -> pkt_len=2, sorted=1, rd_addr 0,1 read 1,2.
